// File: rtl/dm_bytelane.sv
// Byte-lane data memory for the MIPS MEM stage: byte/half/word loads and stores,
// req/ack handshake with a programmable wait-state count and misalignment errors.
module dm_bytelane #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout,
    output logic                  ack,
    output logic                  err,
    output logic                  busy
);
    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  we_reg;
    logic [1:0]            size_reg;
    logic                  sext_reg;
    logic [31:0]           din_reg;
    logic [3:0]            cnt_reg;
    logic [31:0]           dout_reg;
    logic                  ack_reg;
    logic                  err_reg;
    logic [31:0]           rd_word_reg;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        access;
    logic        misalign;
    logic [3:0]  be;
    logic [31:0] st_data;
    logic [31:0] wr_word;
    logic [31:0] lane_shift;
    logic [31:0] load_data;

    assign accept = (state_reg == IDLE) && req;
    assign access = (state_reg == WAIT) && (cnt_reg == 4'd0);
    assign busy   = (state_reg != IDLE);
    assign dout   = dout_reg;
    assign ack    = ack_reg;
    assign err    = err_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = WAIT;
            WAIT:    if (cnt_reg == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane enables and replicated store data; the lane mux below picks per byte.
    always_comb begin
        misalign = 1'b0;
        be       = 4'b0000;
        st_data  = din_reg;
        case (size_reg)
            2'b00: begin
                be      = 4'b0001 << addr_reg[1:0];
                st_data = {4{din_reg[7:0]}};
            end
            2'b01: begin
                misalign = addr_reg[0];
                be       = addr_reg[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{din_reg[15:0]}};
            end
            2'b10: begin
                misalign = (addr_reg[1:0] != 2'b00);
                be       = 4'b1111;
            end
            default: misalign = 1'b1;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_word[8*gi +: 8] = be[gi] ? st_data[8*gi +: 8] : rd_word_reg[8*gi +: 8];
        end
    endgenerate

    assign lane_shift = rd_word_reg >> {addr_reg[1:0], 3'b000};

    always_comb begin
        load_data = rd_word_reg;
        case (size_reg)
            2'b00:   load_data = {{24{sext_reg & lane_shift[7]}}, lane_shift[7:0]};
            2'b01:   load_data = {{16{sext_reg & lane_shift[15]}}, lane_shift[15:0]};
            default: load_data = rd_word_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            size_reg  <= 2'b00;
            sext_reg  <= 1'b0;
            din_reg   <= 32'd0;
            cnt_reg   <= 4'd0;
            dout_reg  <= 32'd0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        addr_reg <= addr;
                        we_reg   <= we;
                        size_reg <= size;
                        sext_reg <= sext;
                        din_reg  <= din;
                        cnt_reg  <= 4'(WAIT_CYCLES);
                    end
                end
                WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        ack_reg  <= 1'b1;
                        err_reg  <= misalign;
                        dout_reg <= (misalign || we_reg) ? 32'd0 : load_data;
                    end
                end
                default: begin
                    ack_reg  <= 1'b0;
                    err_reg  <= 1'b0;
                    dout_reg <= 32'd0;
                end
            endcase
        end
    end

    // The word is fetched at acceptance; nothing can write it before the access edge.
    always_ff @(posedge clk) begin
        if (accept)
            rd_word_reg <= mem[addr[ADDR_WIDTH-1:2]];
        if (access && we_reg && !misalign)
            mem[addr_reg[ADDR_WIDTH-1:2]] <= wr_word;
    end
endmodule

// File: tb/tb_dm_bytelane.sv
// Randomised and directed bench for dm_bytelane against a byte-array memory model.
module tb_dm_bytelane;
    localparam int AW = 8;
    localparam int WC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    size = 2'b00;
    logic          sext = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   din = 32'd0;
    logic [31:0]   dout;
    logic          ack;
    logic          err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] bmem [256];

    dm_bytelane #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .din(din), .dout(dout), .ack(ack), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input logic [7:0] a, input logic [1:0] sz);
        return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] a, input logic [1:0] sz, input logic sx);
        logic [31:0] v;
        int n;
        n = nbytes(sz);
        v = 32'd0;
        for (int i = 0; i < n; i++)
            v = v | (32'(bmem[int'(a) + i]) << (8 * i));
        if (sx && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Assumes it is entered just after a falling edge; leaves just after one.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                             input logic [7:0] a, input logic [31:0] d, input bit hold);
        bit          bad;
        logic [31:0] exp_dout;
        int          cycles;
        bit          seen;
        bad      = is_bad(a, sz);
        exp_dout = (w || bad) ? 32'd0 : model_load(a, sz, sx);
        req  = 1'b1;
        we   = w;
        size = sz;
        sext = sx;
        addr = a;
        din  = d;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (ack) begin
                seen = 1'b1;
            end else begin
                check("busy_wait", 32'(busy), 32'd1);
                we   = $urandom_range(0, 1);
                size = 2'($urandom_range(0, 3));
                addr = 8'($urandom);
                din  = $urandom;
            end
        end
        check("latency", 32'(cycles), 32'(WC + 2));
        check("err", 32'(err), 32'(bad));
        check("dout", dout, exp_dout);
        $display("txn we=%0d size=%0d sext=%0d addr=%02h din=%08h -> dout=%08h err=%0d lat=%0d",
                 w, sz, sx, a, d, dout, err, cycles);
        if (w && !bad)
            for (int i = 0; i < nbytes(sz); i++)
                bmem[int'(a) + i] = d[8*i +: 8];
        if (!hold)
            req = 1'b0;
        @(negedge clk);
        check("ack_drop", 32'(ack), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            bmem[i] = 8'h00;
        @(negedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clear every word so the model and the array agree from the start.
        for (int wd = 0; wd < 64; wd++)
            do_access(1'b1, 2'b10, 1'b0, 8'(wd * 4), 32'd0, 1'b0);

        // Word, byte and half paths.
        do_access(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0);
        do_access(1'b0, 2'b10, 1'b0, 8'h10, 32'd0, 1'b0);
        check("lw_const", model_load(8'h10, 2'b10, 1'b0), 32'hDEADBEEF);
        do_access(1'b1, 2'b10, 1'b0, 8'h10, 32'd0, 1'b0);
        do_access(1'b1, 2'b00, 1'b0, 8'h11, 32'hFFFFFF80, 1'b0);
        do_access(1'b0, 2'b10, 1'b0, 8'h10, 32'd0, 1'b0);
        do_access(1'b0, 2'b00, 1'b1, 8'h11, 32'd0, 1'b0);
        do_access(1'b0, 2'b00, 1'b0, 8'h11, 32'd0, 1'b0);
        do_access(1'b1, 2'b10, 1'b0, 8'h10, 32'h11223344, 1'b0);
        do_access(1'b1, 2'b01, 1'b0, 8'h12, 32'h00008001, 1'b0);
        do_access(1'b0, 2'b10, 1'b0, 8'h10, 32'd0, 1'b0);
        check("sh_const", model_load(8'h10, 2'b10, 1'b0), 32'h80013344);
        do_access(1'b0, 2'b01, 1'b1, 8'h12, 32'd0, 1'b0);
        do_access(1'b0, 2'b01, 1'b0, 8'h12, 32'd0, 1'b0);

        // Error cases, then confirm nothing was written.
        do_access(1'b1, 2'b10, 1'b0, 8'h13, 32'hCAFEF00D, 1'b0);
        do_access(1'b0, 2'b01, 1'b1, 8'h01, 32'd0, 1'b0);
        do_access(1'b1, 2'b11, 1'b0, 8'h00, 32'h55AA55AA, 1'b0);
        do_access(1'b0, 2'b10, 1'b0, 8'h10, 32'd0, 1'b0);
        do_access(1'b0, 2'b10, 1'b0, 8'h00, 32'd0, 1'b0);

        // Reset in the middle of a store's wait states drops the store.
        req  = 1'b1; we = 1'b1; size = 2'b10; sext = 1'b0; addr = 8'h20; din = 32'hA5A5A5A5;
        @(negedge clk);
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_dout", dout, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_access(1'b0, 2'b10, 1'b0, 8'h20, 32'd0, 1'b0);

        // Back-to-back with req held through RESP.
        do_access(1'b1, 2'b10, 1'b0, 8'h24, 32'h01020304, 1'b1);
        do_access(1'b0, 2'b00, 1'b0, 8'h26, 32'd0, 1'b1);
        do_access(1'b0, 2'b10, 1'b0, 8'h24, 32'd0, 1'b0);

        // Random mix.
        for (int n = 0; n < 200; n++)
            do_access(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      8'($urandom), $urandom, bit'($urandom_range(0, 1)));
        req = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
